// File: rtl/snake_map_multi_pkg.sv
// Shared types for the multi-snake occupancy map: FSM states, the empty owner code and
// the cell index helper used by the owner RAM.
package snake_map_multi_pkg;

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StCheck,
    StPop,
    StGrow,
    StDone
  } state_e;

  localparam int unsigned OwnerEmpty = 0;

  function automatic int unsigned cell_index(input int unsigned x, input int unsigned y,
                                             input int unsigned w);
    return y * w + x;
  endfunction

endpackage

// File: rtl/snake_owner_ram.sv
// Owner-code register array: one write port with clear-sweep priority, a query read port
// for the renderer and a second read port for collision checks and tail pops.
module snake_owner_ram
  import snake_map_multi_pkg::*;
#(
  parameter int unsigned GridW = 8,
  parameter int unsigned GridH = 6,
  parameter int unsigned XW    = 3,
  parameter int unsigned YW    = 3,
  parameter int unsigned IW    = 2,
  parameter int unsigned CW    = 6
) (
  input  logic          clk,
  input  logic          clr_en_i,
  input  logic [CW-1:0] clr_idx_i,
  input  logic          we_i,
  input  logic [XW-1:0] wx_i,
  input  logic [YW-1:0] wy_i,
  input  logic [IW-1:0] wdata_i,
  input  logic [XW-1:0] q_x_i,
  input  logic [YW-1:0] q_y_i,
  output logic [IW-1:0] q_owner_o,
  input  logic [XW-1:0] c_x_i,
  input  logic [YW-1:0] c_y_i,
  output logic [IW-1:0] c_owner_o
);

  localparam int unsigned Cells = GridW * GridH;

  logic [IW-1:0] mem_q [Cells];

  logic          w_in, q_in, c_in;
  logic [CW-1:0] w_idx, q_idx, c_idx;

  // Off-grid coordinates never alias onto a real cell: writes drop, reads return empty.
  assign w_in  = (32'(wx_i) < GridW) && (32'(wy_i) < GridH);
  assign q_in  = (32'(q_x_i) < GridW) && (32'(q_y_i) < GridH);
  assign c_in  = (32'(c_x_i) < GridW) && (32'(c_y_i) < GridH);
  assign w_idx = CW'(cell_index(32'(wx_i), 32'(wy_i), GridW));
  assign q_idx = CW'(cell_index(32'(q_x_i), 32'(q_y_i), GridW));
  assign c_idx = CW'(cell_index(32'(c_x_i), 32'(c_y_i), GridW));

  always_ff @(posedge clk) begin
    if (clr_en_i) begin
      mem_q[clr_idx_i] <= '0;
    end else if (we_i && w_in) begin
      mem_q[w_idx] <= wdata_i;
    end
  end

  assign q_owner_o = q_in ? mem_q[q_idx] : '0;
  assign c_owner_o = c_in ? mem_q[c_idx] : '0;

endmodule

// File: rtl/snake_map_multi.sv
// Multi-snake occupancy map: per tick runs check, pop and grow passes over all channels
// and reports a registered per-snake collision vector.
module snake_map_multi
  import snake_map_multi_pkg::*;
#(
  parameter int unsigned GRID_W     = 8,
  parameter int unsigned GRID_H     = 6,
  parameter int unsigned XW         = 3,
  parameter int unsigned YW         = 3,
  parameter int unsigned NUM_SNAKES = 2,
  parameter int unsigned IW         = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic                          clear_req,
  input  logic [NUM_SNAKES-1:0]         alive,
  input  logic [NUM_SNAKES-1:0]         eat,
  input  logic [NUM_SNAKES*(XW+YW)-1:0] head_xy,
  input  logic [NUM_SNAKES*(XW+YW)-1:0] tail_xy,
  input  logic [NUM_SNAKES*(XW+YW)-1:0] next_xy,
  input  logic [XW-1:0]                 q_x,
  input  logic [YW-1:0]                 q_y,
  output logic                          body_on,
  output logic [IW-1:0]                 body_id,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_SNAKES-1:0]         hit,
  output logic                          tick_drop
);

  localparam int unsigned PW    = XW + YW;
  localparam int unsigned Cells = GRID_W * GRID_H;
  localparam int unsigned CW    = (Cells > 1) ? $clog2(Cells) : 1;
  localparam int unsigned ChW   = (NUM_SNAKES > 1) ? $clog2(NUM_SNAKES) : 1;

  state_e                      state_q, state_d;
  logic [CW-1:0]               clr_q, clr_d;
  logic [ChW-1:0]              ch_q, ch_d;
  logic [NUM_SNAKES-1:0]       hit_acc_q, hit_acc_d, hit_q, hit_d;
  logic                        tick_drop_q, tick_drop_d;
  logic                        latch_en;
  logic [NUM_SNAKES-1:0]       alive_q, eat_q;
  logic [NUM_SNAKES*PW-1:0]    head_q, tail_q, next_q;

  logic [PW-1:0] cur_head, cur_tail, cur_next, c_xy, w_xy;
  logic [IW-1:0] own_cur, c_owner, q_owner, w_data;
  logic          last_ch, occupied, head_on, we;

  assign cur_head = head_q[32'(ch_q)*PW +: PW];
  assign cur_tail = tail_q[32'(ch_q)*PW +: PW];
  assign cur_next = next_q[32'(ch_q)*PW +: PW];
  assign own_cur  = IW'(32'(ch_q) + 1);
  assign last_ch  = (32'(ch_q) == NUM_SNAKES - 1);
  // The check port looks at the tail while popping and at the next head otherwise.
  assign c_xy     = (state_q == StPop) ? cur_tail : cur_next;

  always_comb begin
    occupied = 1'b0;
    head_on  = 1'b0;
    if (c_owner != IW'(OwnerEmpty)) begin
      occupied = 1'b1;
      for (int j = 0; j < NUM_SNAKES; j++) begin
        if (c_owner == IW'(j + 1) && tail_q[j*PW +: PW] == cur_next && alive_q[j] && !eat_q[j]) begin
          occupied = 1'b0;
        end
      end
    end
    for (int m = 0; m < NUM_SNAKES; m++) begin
      if (32'(m) != 32'(ch_q) && alive_q[m] && next_q[m*PW +: PW] == cur_next) begin
        head_on = 1'b1;
      end
    end
  end

  always_comb begin
    we     = 1'b0;
    w_xy   = cur_head;
    w_data = own_cur;
    if (state_q == StPop) begin
      we     = alive_q[ch_q] && !eat_q[ch_q] && (c_owner == own_cur);
      w_xy   = cur_tail;
      w_data = '0;
    end else if (state_q == StGrow) begin
      we     = alive_q[ch_q];
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_d       = clr_q;
    ch_d        = ch_q;
    hit_acc_d   = hit_acc_q;
    hit_d       = hit_q;
    latch_en    = 1'b0;
    tick_drop_d = tick && (state_q != StIdle);
    unique case (state_q)
      StClear: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == CW'(Cells - 1)) begin
          clr_d   = '0;
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (tick) begin
          latch_en  = 1'b1;
          ch_d      = '0;
          hit_acc_d = '0;
          state_d   = StCheck;
        end else if (clear_req) begin
          clr_d   = '0;
          state_d = StClear;
        end
      end
      StCheck: begin
        hit_acc_d[ch_q] = alive_q[ch_q] && (occupied || head_on);
        ch_d            = last_ch ? '0 : ch_q + 1'b1;
        if (last_ch) state_d = StPop;
      end
      StPop: begin
        ch_d = last_ch ? '0 : ch_q + 1'b1;
        if (last_ch) state_d = StGrow;
      end
      StGrow: begin
        ch_d = last_ch ? '0 : ch_q + 1'b1;
        if (last_ch) begin
          hit_d   = hit_acc_q;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: begin
        clr_d   = '0;
        state_d = StClear;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StClear;
      clr_q       <= '0;
      ch_q        <= '0;
      hit_acc_q   <= '0;
      hit_q       <= '0;
      tick_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      ch_q        <= ch_d;
      hit_acc_q   <= hit_acc_d;
      hit_q       <= hit_d;
      tick_drop_q <= tick_drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (latch_en) begin
      alive_q <= alive;
      eat_q   <= eat;
      head_q  <= head_xy;
      tail_q  <= tail_xy;
      next_q  <= next_xy;
    end
  end

  snake_owner_ram #(
    .GridW(GRID_W),
    .GridH(GRID_H),
    .XW   (XW),
    .YW   (YW),
    .IW   (IW),
    .CW   (CW)
  ) u_ram (
    .clk      (clk),
    .clr_en_i (state_q == StClear),
    .clr_idx_i(clr_q),
    .we_i     (we),
    .wx_i     (w_xy[PW-1:YW]),
    .wy_i     (w_xy[YW-1:0]),
    .wdata_i  (w_data),
    .q_x_i    (q_x),
    .q_y_i    (q_y),
    .q_owner_o(q_owner),
    .c_x_i    (c_xy[PW-1:YW]),
    .c_y_i    (c_xy[YW-1:0]),
    .c_owner_o(c_owner)
  );

  assign body_on   = (q_owner != IW'(OwnerEmpty));
  assign body_id   = q_owner;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign hit       = hit_q;
  assign tick_drop = tick_drop_q;

endmodule
